// File: rtl/heater_window_driver.sv
// Time-proportioning heater drive: one on/off window per PERIOD clocks, on-time latched
// from the upstream converter at each window boundary, with pulse clamping and fault lockout.
module heater_window_driver #(
  parameter int unsigned PERIOD    = 28800954,
  parameter int unsigned MIN_PULSE = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        fault,
  input  logic [24:0] time_value,
  output logic        sample_req,
  output logic        heater_on,
  output logic        window_start,
  output logic [24:0] duty_latched,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOn   = 2'b01,
    StOff  = 2'b10,
    StLock = 2'b11
  } state_e;

  localparam logic [24:0] PeriodW  = 25'(PERIOD);
  localparam logic [24:0] MinW     = 25'(MIN_PULSE);
  localparam logic [24:0] LastCnt  = 25'(PERIOD - 1);
  // Request is registered, so it is raised on the edge leaving cnt == PERIOD-3.
  localparam logic [24:0] SreqPrev = 25'(PERIOD - 3);

  state_e      state_q;
  logic [24:0] cnt_q;
  logic [24:0] clamp_val;
  logic        running;
  logic        start_evt;

  always_comb begin
    clamp_val = time_value;
    if (time_value >= PeriodW) begin
      clamp_val = PeriodW;
    end else if (time_value < MinW) begin
      clamp_val = '0;
    end else if ((PeriodW - time_value) < MinW) begin
      clamp_val = PeriodW;
    end
  end

  always_comb begin
    running   = (state_q == StOn) || (state_q == StOff);
    start_evt = !fault && en && ((state_q == StIdle) || (running && (cnt_q == LastCnt)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      duty_latched <= '0;
      heater_on    <= 1'b0;
      sample_req   <= 1'b0;
      window_start <= 1'b0;
    end else begin
      sample_req   <= 1'b0;
      window_start <= 1'b0;
      if (fault) begin
        state_q      <= StLock;
        cnt_q        <= '0;
        duty_latched <= '0;
        heater_on    <= 1'b0;
      end else if (running && !en) begin
        state_q      <= StIdle;
        cnt_q        <= '0;
        duty_latched <= '0;
        heater_on    <= 1'b0;
      end else if (start_evt) begin
        cnt_q        <= '0;
        duty_latched <= clamp_val;
        window_start <= 1'b1;
        if (clamp_val != '0) begin
          state_q   <= StOn;
          heater_on <= 1'b1;
        end else begin
          state_q   <= StOff;
          heater_on <= 1'b0;
        end
      end else begin
        case (state_q)
          StOn, StOff: begin
            cnt_q      <= cnt_q + 25'd1;
            sample_req <= (cnt_q == SreqPrev);
            // A full-period duty never turns off; the wrap restarts the window instead.
            if ((state_q == StOn) && (duty_latched < PeriodW) &&
                (cnt_q == duty_latched - 25'd1)) begin
              state_q   <= StOff;
              heater_on <= 1'b0;
            end
          end
          StLock: begin
            if (!en) begin
              state_q <= StIdle;
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_heater_window_driver.sv
// Self-checking bench for heater_window_driver: directed scenarios plus randomized run
// against a window-position reference model (PERIOD=100, MIN_PULSE=10).
module tb_heater_window_driver;

  localparam int P  = 100;
  localparam int MP = 10;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        fault = 1'b0;
  logic [24:0] tv    = '0;
  logic        sample_req;
  logic        heater_on;
  logic        window_start;
  logic [24:0] duty_latched;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  heater_window_driver #(
    .PERIOD   (P),
    .MIN_PULSE(MP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .fault       (fault),
    .time_value  (tv),
    .sample_req  (sample_req),
    .heater_on   (heater_on),
    .window_start(window_start),
    .duty_latched(duty_latched),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Reference model: mode (0 idle, 1 running, 2 locked), position in window, latched duty.
  int m_mode = 0;
  int m_pos  = 0;
  int m_duty = 0;

  function automatic int clamp_ref(int v);
    if (v >= P) return P;
    if (v < MP) return 0;
    if (P - v < MP) return P;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_pos <= 0; m_duty <= 0;
    end else if (fault) begin
      m_mode <= 2; m_pos <= 0; m_duty <= 0;
    end else if (m_mode == 1 && !en) begin
      m_mode <= 0; m_pos <= 0; m_duty <= 0;
    end else if ((m_mode == 0 && en) || (m_mode == 1 && m_pos == P - 1)) begin
      m_mode <= 1; m_pos <= 0; m_duty <= clamp_ref(int'(tv));
    end else if (m_mode == 1) begin
      m_pos <= m_pos + 1;
    end else if (m_mode == 2 && !en) begin
      m_mode <= 0;
    end
  end

  logic [1:0]  exp_st;
  logic [29:0] exp_vec;
  logic [29:0] obs_vec;

  always_comb begin
    exp_st = 2'd0;
    if (m_mode == 2) exp_st = 2'd3;
    else if (m_mode == 1) exp_st = (m_pos < m_duty) ? 2'd1 : 2'd2;
    exp_vec = {exp_st, exp_st == 2'd1, (m_mode == 1 && m_pos == P - 2),
               (m_mode == 1 && m_pos == 0), (m_mode == 1) ? 25'(m_duty) : 25'd0};
  end

  assign obs_vec = {state, heater_on, sample_req, window_start, duty_latched};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; en = 1'b0; fault = 1'b0; tv = '0;
    repeat (3) tick();
    n_tests++;
    if (obs_vec !== 30'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, expected 0", obs_vec);
    end
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (obs_vec !== 30'd0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL reset_quiet: %0d non-zero cycles, expected 0", bad);
    end
  endtask

  task automatic test_nominal();
    int on_cnt, first_off, sreq_n, sreq_at, mism;
    tv = 25'd40; en = 1'b1;
    tick();
    n_tests++;
    if (window_start !== 1'b1 || state !== 2'b01) begin
      n_fail++; $display("FAIL nom_start: ws=%b state=%b, expected ws=1 state=01",
                         window_start, state);
    end
    n_tests++;
    if (duty_latched !== 25'd40) begin
      n_fail++; $display("FAIL nom_duty: got %0d, expected 40", duty_latched);
    end
    on_cnt = 0; first_off = -1; sreq_n = 0; sreq_at = -1; mism = 0;
    for (int i = 0; i < P; i++) begin
      if (heater_on) on_cnt++;
      if (!heater_on && first_off < 0) first_off = i;
      if (sample_req) begin sreq_n++; sreq_at = i; end
      if (obs_vec !== exp_vec) mism++;
      tick();
    end
    n_tests++;
    if (on_cnt != 40 || first_off != 40) begin
      n_fail++; $display("FAIL nom_on: on=%0d first_off=%0d, expected 40 and 40",
                         on_cnt, first_off);
    end
    n_tests++;
    if (sreq_n != 1 || sreq_at != 98) begin
      n_fail++; $display("FAIL nom_sreq: count=%0d at=%0d, expected 1 at 98", sreq_n, sreq_at);
    end
    n_tests++;
    if (window_start !== 1'b1) begin
      n_fail++; $display("FAIL nom_next_ws: got %b, expected 1 at cycle 100", window_start);
    end
    n_tests++;
    if (mism != 0) begin
      n_fail++; $display("FAIL nom_model: %0d cycles differ, expected 0", mism);
    end
  endtask

  task automatic test_clamp();
    int tab  [5] = '{5, 95, 200, 100, 100};
    int expd [5] = '{0, 100, 100, 100, 100};
    int on_cnt, mism;
    mism = 0;
    tv = 25'(tab[0]);
    for (int i = 0; i < P; i++) begin
      if (obs_vec !== exp_vec) mism++;
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (duty_latched !== 25'(expd[k]) || state !== ((expd[k] != 0) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL clamp_duty[%0d] tv=%0d: duty=%0d state=%b, expected duty=%0d",
                           k, tab[k], duty_latched, state, expd[k]);
      end
      tv = (k < 4) ? 25'(tab[k + 1]) : 25'd40;
      on_cnt = 0;
      for (int i = 0; i < P; i++) begin
        if (heater_on) on_cnt++;
        if (obs_vec !== exp_vec) mism++;
        tick();
      end
      n_tests++;
      if (on_cnt != expd[k]) begin
        n_fail++; $display("FAIL clamp_on[%0d]: got %0d on cycles, expected %0d",
                           k, on_cnt, expd[k]);
      end
    end
    n_tests++;
    if (mism != 0) begin
      n_fail++; $display("FAIL clamp_model: %0d cycles differ, expected 0", mism);
    end
  endtask

  task automatic test_midwindow();
    int on_cnt;
    n_tests++;
    if (duty_latched !== 25'd40) begin
      n_fail++; $display("FAIL mid_duty_a: got %0d, expected 40", duty_latched);
    end
    on_cnt = 0;
    for (int i = 0; i < P; i++) begin
      if (heater_on) on_cnt++;
      if (i == 20) tv = 25'd70;
      tick();
    end
    n_tests++;
    if (on_cnt != 40) begin
      n_fail++; $display("FAIL mid_on_a: got %0d, expected 40", on_cnt);
    end
    n_tests++;
    if (duty_latched !== 25'd70) begin
      n_fail++; $display("FAIL mid_duty_b: got %0d, expected 70", duty_latched);
    end
    on_cnt = 0;
    for (int i = 0; i < P; i++) begin
      if (heater_on) on_cnt++;
      tick();
    end
    n_tests++;
    if (on_cnt != 70) begin
      n_fail++; $display("FAIL mid_on_b: got %0d, expected 70", on_cnt);
    end
  endtask

  task automatic test_fault();
    int bad;
    repeat (15) tick();
    n_tests++;
    if (state !== 2'b01) begin
      n_fail++; $display("FAIL fault_pre: state=%b, expected 01", state);
    end
    fault = 1'b1;
    tick();
    n_tests++;
    if (heater_on !== 1'b0 || state !== 2'b11 || duty_latched !== 25'd0) begin
      n_fail++; $display("FAIL fault_lock: heater=%b state=%b duty=%0d, expected 0 11 0",
                         heater_on, state, duty_latched);
    end
    fault = 1'b0;
    bad = 0;
    repeat (10) begin
      tick();
      if (state !== 2'b11 || heater_on || window_start || sample_req) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL fault_hold: %0d cycles left lock, expected 0", bad);
    end
    en = 1'b0;
    tick();
    n_tests++;
    if (state !== 2'b00) begin
      n_fail++; $display("FAIL fault_exit: state=%b, expected 00", state);
    end
    en = 1'b1;
    tick();
    n_tests++;
    if (window_start !== 1'b1 || state !== 2'b01 || obs_vec !== exp_vec) begin
      n_fail++; $display("FAIL fault_rearm: got %h, expected %h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_async_reset();
    int mism;
    repeat (25) tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (heater_on !== 1'b0 || state !== 2'b00 || obs_vec !== 30'd0) begin
      n_fail++; $display("FAIL async_reset: got %h, expected 0", obs_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (window_start !== 1'b1 || duty_latched !== 25'd70 || state !== 2'b01) begin
      n_fail++; $display("FAIL async_restart: ws=%b duty=%0d state=%b, expected 1 70 01",
                         window_start, duty_latched, state);
    end
    mism = 0;
    for (int i = 0; i < 2 * P; i++) begin
      if (obs_vec !== exp_vec) mism++;
      tick();
    end
    n_tests++;
    if (mism != 0) begin
      n_fail++; $display("FAIL async_model: %0d cycles differ, expected 0", mism);
    end
  endtask

  task automatic test_random();
    int          edges [8] = '{0, 9, 10, 90, 91, 99, 100, 101};
    int          mism;
    int          first_at;
    logic [29:0] f_obs;
    logic [29:0] f_exp;
    mism = 0; first_at = -1; f_obs = '0; f_exp = '0;
    for (int c = 0; c < 4000; c++) begin
      if (obs_vec !== exp_vec) begin
        if (mism == 0) begin first_at = c; f_obs = obs_vec; f_exp = exp_vec; end
        mism++;
      end
      en    = ($urandom_range(0, 149) != 0);
      fault = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 1) == 0) tv = 25'($urandom_range(0, 120));
        else tv = 25'(edges[$urandom_range(0, 7)]);
      end
      tick();
    end
    fault = 1'b0;
    n_tests++;
    if (mism != 0) begin
      n_fail++; $display("FAIL random_model: %0d cycles differ; first at %0d got %h expected %h",
                         mism, first_at, f_obs, f_exp);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_clamp();
    test_midwindow();
    test_fault();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/heater_window_driver.md
Name: heater_window_driver

Overview:
- Time-proportioning output stage directly downstream of the PID-response-to-time-count converter.
- Each fixed-length control window, latches the converter's 25-bit on-time count and drives the heater relay/SSR high for that many clocks, then low for the remainder of the window.
- Issues a one-cycle sample request to the converter so that a fresh count is ready exactly at each window boundary.
- Enforces minimum pulse widths for relay protection and provides a latched fault lockout.

Parameters:
- PERIOD, 28800954, window length in clocks (63 × 457158, i.e. a count of PERIOD is 100% on); must be < 2^25.
- MIN_PULSE, 500000, minimum on-time and off-time in clocks; shorter pulses are suppressed.

Ports:
- CLK  input  1  system clock
- RST_N  input  1  asynchronous active-low reset
- EN  input  1  run enable; 0 forces IDLE
- FAULT  input  1  over-temperature/safety fault, level-sensitive, highest priority
- TIME_VALUE  input  25  on-time count from converter (registered upstream)
- SAMPLE_REQ  output  1  one-cycle pulse; drives the converter's EN
- HEATER_ON  output  1  heater drive
- WINDOW_START  output  1  one-cycle pulse in the first cycle of every window
- DUTY_LATCHED  output  25  clamped on-time in effect for the current window
- STATE  output  2  IDLE=00, ON=01, OFF=10, LOCK=11

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N. While RST_N=0, all outputs are 0, STATE=IDLE, and the internal window counter cnt=0.
- Registering: all outputs are registered.
- HEATER_ON: equals (STATE==ON).
- Counter: cnt is 25 bits, counts 0..PERIOD-1 while in ON or OFF, then wraps to 0. cnt is held at 0 in IDLE and LOCK.
- Clamp, applied to TIME_VALUE at capture (priority order):
  - TIME_VALUE >= PERIOD → PERIOD.
  - TIME_VALUE < MIN_PULSE → 0.
  - PERIOD - TIME_VALUE < MIN_PULSE → PERIOD.
  - Otherwise → TIME_VALUE.
- Window start event (IDLE with EN=1 and FAULT=0, or ON/OFF with cnt==PERIOD-1):
  - On the next edge: cnt←0, DUTY_LATCHED←clamp(TIME_VALUE), WINDOW_START←1 for that one cycle.
  - STATE←ON if the clamped value > 0, else OFF.
- ON→OFF: at the edge where cnt==DUTY_LATCHED-1 and DUTY_LATCHED<PERIOD, provided no window start event occurs on the same edge.
  - HEATER_ON is therefore high for exactly DUTY_LATCHED cycles per window.
- OFF: remains OFF until the window start event.
- SAMPLE_REQ: high during the single cycle with cnt==PERIOD-2 in ON or OFF. The converter updates TIME_VALUE on that edge, so the new value is present during cnt==PERIOD-1 and is captured at the wrap. SAMPLE_REQ is never asserted in IDLE or LOCK.
- EN=0 in ON/OFF: next edge STATE←IDLE, HEATER_ON←0, cnt←0, DUTY_LATCHED←0. This takes priority over wrap and the ON→OFF transition.
- FAULT=1 in any state: next edge STATE←LOCK, HEATER_ON←0, cnt←0, DUTY_LATCHED←0, no pulses. Overrides EN and all other events.
- LOCK exit: only to IDLE, and only on an edge with FAULT=0 and EN=0. FAULT clearing while EN=1 keeps LOCK (manual re-arm required).
- Reset mid-operation: immediate asynchronous return to reset values, including HEATER_ON=0 with no glitch beyond reset assertion.
- Boundary cases:
  - A TIME_VALUE change mid-window has no effect until the next capture.
  - DUTY_LATCHED==PERIOD gives continuous HEATER_ON across consecutive windows with no off cycle at the wrap.
  - DUTY_LATCHED==0 gives no on cycle.

Test Plan (PERIOD=100, MIN_PULSE=10):
- Reset: assert RST_N=0 for 3 cycles then release with EN=0 → all outputs 0, STATE=00, no pulses for 200 cycles.
- Nominal window: TIME_VALUE=40, raise EN → WINDOW_START at window cycle 0, DUTY_LATCHED=40, HEATER_ON high for exactly 40 cycles then low for 60, SAMPLE_REQ once at cnt=98, next WINDOW_START 100 cycles after the first.
- Clamping: TIME_VALUE=5 → HEATER_ON never high, STATE=OFF. TIME_VALUE=95 → HEATER_ON high all 100 cycles, DUTY_LATCHED=100. TIME_VALUE=200 → DUTY_LATCHED=100. Two consecutive windows at 100 → HEATER_ON never drops at the wrap.
- Mid-window update: TIME_VALUE 40→70 at cnt=20 → current window still 40 on cycles, next window 70 on cycles.
- Fault: FAULT=1 at cnt=15 in ON → HEATER_ON=0 and STATE=11 on the next edge. FAULT=0 with EN=1 → remains LOCK. Drop EN → IDLE. Re-raise EN → new window with a WINDOW_START pulse.
- Async reset mid-ON: drop RST_N at cnt=25 between clock edges → HEATER_ON=0 and STATE=00 immediately. After release with EN=1 → a fresh window starts from cnt=0.
